// File: rtl/rr_arbiter_fsm_pkg.sv
// Shared definitions for the round-robin arbiter: controller state encoding,
// default hold limit, hold counter width and a small modulo helper.
package rr_arbiter_fsm_pkg;

    // Controller states. The 2'b11 code is unused and recovers to idle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_GNT  = 2'b01,
        ST_GAP  = 2'b10
    } state_t;

    // Default number of consecutive grant cycles in one tenure.
    localparam int HOLD_MAX_DEFAULT = 16;

    // The tenure counter is 8 bits wide. It is cleared on every grant, so
    // with HOLD_MAX <= 255 it cannot wrap.
    localparam int HOLD_W = 8;

    // (a + b) mod n, for a < n and b <= n. This avoids a real modulo operator
    // in the index arithmetic.
    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/rr_arbiter_fsm_if.sv
// Request/grant bundle between the requesters and the arbiter.
// The master side is the arbiter, which drives the grant and the status
// signals. The slave side is the requesters and the datapath.
interface rr_arbiter_fsm_if #(
    parameter int N  = 4,
    parameter int IW = 2
);
    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic [IW-1:0] owner;
    logic          busy;
    logic          timeout_tick;

    modport master (
        input  req,
        output grant,
        output owner,
        output busy,
        output timeout_tick
    );

    modport slave (
        output req,
        input  grant,
        input  owner,
        input  busy,
        input  timeout_tick
    );
endinterface

// File: rtl/rr_arbiter_fsm_pick.sv
// rr_pick: a combinational circular priority encoder. It returns the first
// set bit of req when scanning ptr, ptr+1, ... and wraps from N-1 to 0.
module rr_pick
    import rr_arbiter_fsm_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // cand[k] is the requester index at scan offset k from ptr.
    logic [IW-1:0] cand [N];
    logic [N-1:0]  hit;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_offset
            assign cand[gi] = IW'(wrap_add(int'(ptr), gi, N));
            assign hit[gi]  = req[cand[gi]];
        end
    endgenerate

    // Select the lowest scan offset that has a request. The loop runs
    // downward so that the smallest offset is written last and wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (hit[j]) begin
                valid = 1'b1;
                idx   = cand[j];
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_fsm.sv
// Round-robin arbiter with a Moore controller (idle -> gnt -> gap -> idle).
// The grant is decoded from the state and owner registers only. A tenure ends
// when the owner drops its request or when it reaches HOLD_MAX cycles.
module rr_arbiter_fsm
    import rr_arbiter_fsm_pkg::*;
#(
    parameter int N        = 4,
    parameter int IW       = 2,
    parameter int HOLD_MAX = HOLD_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    rr_arbiter_fsm_if.master  bus
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

    state_t             state_reg, state_next;
    logic [IW-1:0]      owner_reg, owner_next;
    logic [IW-1:0]      ptr_reg, ptr_next;
    logic [HOLD_W-1:0]  hold_cnt_reg, hold_cnt_next;
    logic               timeout_reg, timeout_next;

    logic               pick_valid;
    logic [IW-1:0]      pick_idx;
    logic [IW-1:0]      owner_inc;
    logic               owner_req;
    logic [N-1:0]       owner_onehot;

    logic [N-1:0]       grant;
    logic               busy;
    logic               timeout_tick;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req   (bus.req),
        .ptr   (ptr_reg),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // The priority pointer moves to the slot just after the owner that leaves.
    assign owner_inc = IW'(wrap_add(int'(owner_reg), 1, N));
    assign owner_req = bus.req[owner_reg];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_decode
            assign owner_onehot[gi] = (owner_reg == IW'(gi));
        end
    endgenerate

    // State, pointer, owner, counter and timeout-flag registers, async reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            owner_reg    <= '0;
            ptr_reg      <= '0;
            hold_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            ptr_reg      <= ptr_next;
            hold_cnt_reg <= hold_cnt_next;
            timeout_reg  <= timeout_next;
        end
    end

    // Next-state logic. A release that coincides with the hold limit counts
    // as a release, so the timeout flag is set only while req is still held.
    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        ptr_next      = ptr_reg;
        hold_cnt_next = hold_cnt_reg;
        timeout_next  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_next    = ST_GNT;
                    owner_next    = pick_idx;
                    hold_cnt_next = '0;
                end
            end
            ST_GNT: begin
                hold_cnt_next = hold_cnt_reg + 1'b1;
                if (!owner_req) begin
                    state_next = ST_GAP;
                    ptr_next   = owner_inc;
                end else if (hold_cnt_reg == HOLD_LAST) begin
                    state_next   = ST_GAP;
                    ptr_next     = owner_inc;
                    timeout_next = 1'b1;
                end
            end
            ST_GAP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Moore output decode. Every state other than gnt, including illegal
    // codes, drives an all-zero grant.
    always_comb begin
        grant        = '0;
        busy         = 1'b0;
        timeout_tick = 1'b0;
        case (state_reg)
            ST_GNT: begin
                grant = owner_onehot;
                busy  = 1'b1;
            end
            ST_GAP: begin
                timeout_tick = timeout_reg;
            end
            default: begin
                grant        = '0;
                busy         = 1'b0;
                timeout_tick = 1'b0;
            end
        endcase
    end

    assign bus.grant        = grant;
    assign bus.owner        = owner_reg;
    assign bus.busy         = busy;
    assign bus.timeout_tick = timeout_tick;

endmodule

// File: tb/tb_rr_arbiter_fsm.sv
// Directed bench for rr_arbiter_fsm with N=4 and HOLD_MAX=16. Inputs change
// and outputs are sampled on the falling clock edge.
module tb_rr_arbiter_fsm;

    localparam int N        = 4;
    localparam int IW       = 2;
    localparam int HOLD_MAX = 16;

    logic clk;
    logic reset;

    int errors = 0;
    int checks = 0;

    rr_arbiter_fsm_if #(.N(N), .IW(IW)) bus ();

    rr_arbiter_fsm #(
        .N        (N),
        .IW       (IW),
        .HOLD_MAX (HOLD_MAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: value=%0h", tag, got);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    int order [5] = '{0, 1, 2, 3, 0};

    initial begin
        logic [3:0] exp_g;

        // Hold reset with every requester active.
        reset   = 1'b1;
        bus.req = 4'b1111;
        step();
        step();
        check("rst_grant", 32'(bus.grant), 32'h0);
        check("rst_owner", 32'(bus.owner), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_tick", 32'(bus.timeout_tick), 32'h0);
        reset = 1'b0;
        step();
        check("first_grant", 32'(bus.grant), 32'h1);
        check("first_owner", 32'(bus.owner), 32'h0);
        check("first_busy", 32'(bus.busy), 32'h1);

        // Round-robin: each owner holds for 3 cycles, then drops its request
        // and raises it again.
        for (int t = 0; t < 5; t++) begin
            exp_g = 4'b0001 << order[t];
            check($sformatf("rr%0d_grant_c1", t), 32'(bus.grant), 32'(exp_g));
            check($sformatf("rr%0d_owner", t), 32'(bus.owner), 32'(order[t]));
            step();
            check($sformatf("rr%0d_grant_c2", t), 32'(bus.grant), 32'(exp_g));
            step();
            check($sformatf("rr%0d_grant_c3", t), 32'(bus.grant), 32'(exp_g));
            check($sformatf("rr%0d_busy", t), 32'(bus.busy), 32'h1);
            bus.req[order[t]] = 1'b0;
            step();
            check($sformatf("rr%0d_gap_grant", t), 32'(bus.grant), 32'h0);
            check($sformatf("rr%0d_gap_busy", t), 32'(bus.busy), 32'h0);
            bus.req = 4'b1111;
            step();
            check($sformatf("rr%0d_idle_grant", t), 32'(bus.grant), 32'h0);
            step();
        end
        // Requester 1 is now granted because the pointer moved past 0.
        check("rr_next_grant", 32'(bus.grant), 32'h2);
        bus.req = 4'b0000;
        step();
        step();
        check("quiet_grant", 32'(bus.grant), 32'h0);

        // Timeout: requester 2 holds its request until the tenure is cut off.
        bus.req = 4'b0100;
        step();
        for (int i = 0; i < HOLD_MAX; i++) begin
            check($sformatf("to_grant_c%0d", i), 32'(bus.grant), 32'h4);
            check($sformatf("to_tick_c%0d", i), 32'(bus.timeout_tick), 32'h0);
            step();
        end
        check("to_gap_grant", 32'(bus.grant), 32'h0);
        check("to_gap_tick", 32'(bus.timeout_tick), 32'h1);
        step();
        check("to_idle_grant", 32'(bus.grant), 32'h0);
        check("to_idle_tick", 32'(bus.timeout_tick), 32'h0);
        step();
        check("to_regrant", 32'(bus.grant), 32'h4);
        check("to_regrant_owner", 32'(bus.owner), 32'h2);

        // Release on the same cycle as the limit: hold_cnt is 15 after 15 steps.
        for (int i = 1; i < HOLD_MAX; i++) begin
            step();
        end
        check("sim_last_grant", 32'(bus.grant), 32'h4);
        bus.req = 4'b0000;
        step();
        check("sim_gap_grant", 32'(bus.grant), 32'h0);
        check("sim_gap_tick", 32'(bus.timeout_tick), 32'h0);
        step();
        check("sim_idle_tick", 32'(bus.timeout_tick), 32'h0);

        // Wrap and skip. The pointer is now 3.
        bus.req = 4'b1000;
        step();
        check("wrap_owner3", 32'(bus.grant), 32'h8);
        bus.req = 4'b0101;
        step();
        check("wrap_gap", 32'(bus.grant), 32'h0);
        step();
        check("wrap_idle", 32'(bus.grant), 32'h0);
        step();
        check("wrap_grant0", 32'(bus.grant), 32'h1);
        check("wrap_owner0", 32'(bus.owner), 32'h0);
        bus.req = 4'b0100;
        step();
        step();
        step();
        check("skip_grant2", 32'(bus.grant), 32'h4);
        check("skip_owner2", 32'(bus.owner), 32'h2);

        // Async reset between clock edges while the grant is active.
        #2;
        reset = 1'b1;
        #1;
        check("async_grant", 32'(bus.grant), 32'h0);
        check("async_busy", 32'(bus.busy), 32'h0);
        check("async_owner", 32'(bus.owner), 32'h0);
        check("async_tick", 32'(bus.timeout_tick), 32'h0);
        bus.req = 4'b0000;
        step();
        reset = 1'b0;
        step();
        check("post_rst_grant", 32'(bus.grant), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_fsm.md
# rr_arbiter_fsm

Round-robin arbiter that shares one resource between N requesters using a Moore-style controller FSM. Each requester holds `req` for as long as it needs the resource. The arbiter issues a registered one-hot `grant` and forces release after a hold limit. It sits between the FSM-based request sources in the design and the shared datapath, which it sequences via `grant`, `owner` and `busy`.

## Interface

Parameters:
- `N`, 4: number of requesters, 2..8.
- `IW`, 2: width of `owner`; must satisfy 2^IW >= N.
- `HOLD_MAX`, 16: maximum consecutive grant cycles per tenure, 2..255.

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `req`  in  N: request vector. Bit i is held high by requester i for the whole use of the resource.
- `grant`  out  N: registered one-hot grant, or all-zero.
- `owner`  out  IW: index of the current or last granted requester.
- `busy`  out  1: high while in state `gnt`.
- `timeout_tick`  out  1: one-cycle pulse when a tenure is cut off by `HOLD_MAX`.

## Operation

- States:
  - `idle`: waiting for a request.
  - `gnt`: resource owned.
  - `gap`: one-cycle turnaround.
- Outputs are Moore, decoded from registers.
- Rotating priority pointer `ptr`, range 0..N-1.
- `idle`:
  - With `req` == 0, stay in `idle`.
  - Otherwise select the first set bit of `req`, scanning circularly from `ptr` (ptr, ptr+1, …, wrapping N-1→0).
  - Load `owner` with that index, set `grant[owner]`, clear `hold_cnt`, and go to `gnt`.
- `gnt`:
  - `hold_cnt` increments each cycle.
  - If `req[owner]` == 0: go to `gap`.
  - Else if `hold_cnt` == HOLD_MAX-1: go to `gap` and assert `timeout_tick` for exactly one cycle.
  - In both cases `grant` clears and `ptr` ← (owner+1) mod N.
- `gap`: `grant` = 0 for one cycle, then go to `idle` unconditionally. No arbitration happens in `gap`.
- Requests from non-owners during `gnt` are ignored until the next `idle`.
- A requester that timed out and keeps `req` high stays eligible. It ranks last in the next scan because `ptr` has moved past it.
- Simultaneous release and limit (`req[owner]` drops on the cycle `hold_cnt` == HOLD_MAX-1): treated as a release, so `timeout_tick` stays 0.
- Illegal state encodings go to `idle` with `grant` = 0.
- `hold_cnt` width is 8 bits and never wraps: it is cleared on every grant.

## Timing

- Reset values: state `idle`, `grant` = 0, `owner` = 0, `ptr` = 0, `busy` = 0, `timeout_tick` = 0, `hold_cnt` = 0.
- Reset asserted mid-tenure: `grant` and `busy` clear asynchronously, with no `timeout_tick`.
- Grant latency: `req` high before edge k while in `idle` → `grant` high after edge k.
- Release latency: `req[owner]` low before edge k → `grant` low after edge k.
- Dead time: `grant` is 0 after edge k (`gap`) and after edge k+1 (`idle`). The next grant appears after edge k+2 at the earliest.
- Maximum tenure: `grant` high for exactly HOLD_MAX cycles. `timeout_tick` is high during the cycle after the last grant cycle, concurrent with `gap`.
- `busy` is identical to OR of `grant`.
- `grant` is never multi-hot and never changes except on the transitions above.

## Structure

- Shared include `arb_defs.vh` holds:
  - state encodings `IDLE` = 2'b00, `GNT` = 2'b01, `GAP` = 2'b10;
  - default `HOLD_MAX`.
- Two always blocks: the state/pointer/counter register with async reset, and the next-state/output logic with defaults assigned first.
- One sub-module is natural: `rr_pick`, a combinational circular priority encoder with inputs `req` and `ptr` and outputs `valid` and `idx`. It is instantiated once.

## Test plan

- Reset with `req` = 4'b1111 held: after release of `reset`, the first edge gives `grant` = 4'b0001, `owner` = 0, `busy` = 1.
- Round-robin: `req` = 4'b1111, each owner drops its `req` after 3 cycles then re-raises. Grants follow the order 0,1,2,3,0, with exactly 2 zero-grant cycles between tenures.
- Timeout: `req` = 4'b0100 held forever, `HOLD_MAX` = 16.
  - `grant` = 4'b0100 for 16 cycles.
  - `timeout_tick` pulses once.
  - The same requester is re-granted after the 2-cycle gap.
- Simultaneous release and limit: `req[2]` drops on the cycle with `hold_cnt` = 15 → `grant` clears and `timeout_tick` stays 0.
- Wrap and skip: owner 3 releases with `req` = 4'b0101 → next grant is 4'b0001, via wrap from `ptr` = 0. After that releases, the next grant is 4'b0100, skipping bit 1.
- Async reset asserted mid-`gnt` between edges: `grant`, `busy` and `owner` go to 0 immediately, with no clock edge required.
